// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and {tag, word} address layout for the
// single-line cache controller.
package cache_pkg;

    localparam int TAG_W  = 5;
    localparam int WORD_W = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = TAG_W + WORD_W;

    localparam logic [WORD_W-1:0] CNT_MAX = '1;
    localparam logic [WORD_W-1:0] CNT_ONE = WORD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMP    = 3'd1,
        S_WB_RD  = 3'd2,
        S_WB_M   = 3'd3,
        S_FILL_M = 3'd4,
        S_FILL_W = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] word;
    } addr_t;

    function automatic addr_t make_addr(input logic [TAG_W-1:0] tag,
                                        input logic [WORD_W-1:0] word);
        addr_t a;
        a.tag  = tag;
        a.word = word;
        return a;
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Cache controller: sequences way compare/access commands, dirty-line
// write-back and word-by-word refill for one in-flight CPU request.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ready,
    output logic              o_way_en,
    output logic              o_way_comp,
    output logic              o_way_write,
    output logic [WORD_W-1:0] o_way_word,
    output logic [TAG_W-1:0]  o_way_tag,
    output logic [DATA_W-1:0] o_way_data_in,
    output logic              o_way_valid_in,
    input  logic              i_way_ack,
    input  logic              i_way_hit,
    input  logic              i_way_dirty,
    input  logic              i_way_valid_out,
    input  logic [TAG_W-1:0]  i_way_tag_out,
    input  logic [DATA_W-1:0] i_way_data_out,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    state_t            r_state, w_state_next;
    // 0: way command driven, waiting for ack; 1: command dropped, waiting for ack release
    logic              r_phase, w_phase_next;
    logic              r_we, w_we_next;
    addr_t             r_addr, w_addr_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next;
    logic [WORD_W-1:0] r_cnt, w_cnt_next;
    logic [TAG_W-1:0]  r_victim_tag, w_victim_tag_next;
    logic              r_hit, w_hit_next;
    logic              r_victim_dirty, w_victim_dirty_next;
    logic [DATA_W-1:0] r_rdata, w_rdata_next;
    logic [DATA_W-1:0] r_buf, w_buf_next;
    logic              w_last;

    assign w_last = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_phase        <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_cnt          <= '0;
            r_victim_tag   <= '0;
            r_hit          <= 1'b0;
            r_victim_dirty <= 1'b0;
            r_rdata        <= '0;
            r_buf          <= '0;
        end else begin
            r_state        <= w_state_next;
            r_phase        <= w_phase_next;
            r_we           <= w_we_next;
            r_addr         <= w_addr_next;
            r_wdata        <= w_wdata_next;
            r_cnt          <= w_cnt_next;
            r_victim_tag   <= w_victim_tag_next;
            r_hit          <= w_hit_next;
            r_victim_dirty <= w_victim_dirty_next;
            r_rdata        <= w_rdata_next;
            r_buf          <= w_buf_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_phase_next        = r_phase;
        w_we_next           = r_we;
        w_addr_next         = r_addr;
        w_wdata_next        = r_wdata;
        w_cnt_next          = r_cnt;
        w_victim_tag_next   = r_victim_tag;
        w_hit_next          = r_hit;
        w_victim_dirty_next = r_victim_dirty;
        w_rdata_next        = r_rdata;
        w_buf_next          = r_buf;

        case (r_state)
            S_IDLE: begin
                if (i_cpu_req) begin
                    w_we_next    = i_cpu_we;
                    w_addr_next  = addr_t'(i_cpu_addr);
                    w_wdata_next = i_cpu_wdata;
                    w_phase_next = 1'b0;
                    w_state_next = S_CMP;
                end
            end
            S_CMP: begin
                if (!r_phase) begin
                    if (i_way_ack) begin
                        w_hit_next          = i_way_hit;
                        w_victim_dirty_next = i_way_valid_out & i_way_dirty;
                        w_victim_tag_next   = i_way_tag_out;
                        w_rdata_next        = i_way_data_out;
                        w_phase_next        = 1'b1;
                    end
                end else if (!i_way_ack) begin
                    w_phase_next = 1'b0;
                    w_cnt_next   = '0;
                    if (r_hit) begin
                        w_state_next = S_RESP;
                    end else if (r_victim_dirty) begin
                        w_state_next = S_WB_RD;
                    end else begin
                        w_state_next = S_FILL_M;
                    end
                end
            end
            S_WB_RD: begin
                if (!r_phase) begin
                    if (i_way_ack) begin
                        w_buf_next   = i_way_data_out;
                        w_phase_next = 1'b1;
                    end
                end else if (!i_way_ack) begin
                    w_phase_next = 1'b0;
                    w_state_next = S_WB_M;
                end
            end
            S_WB_M: begin
                if (i_mem_ack) begin
                    if (w_last) begin
                        w_cnt_next   = '0;
                        w_state_next = S_FILL_M;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                        w_state_next = S_WB_RD;
                    end
                end
            end
            S_FILL_M: begin
                if (i_mem_ack) begin
                    w_buf_next   = i_mem_rdata;
                    w_phase_next = 1'b0;
                    w_state_next = S_FILL_W;
                end
            end
            S_FILL_W: begin
                if (!r_phase) begin
                    if (i_way_ack) begin
                        w_phase_next = 1'b1;
                    end
                end else if (!i_way_ack) begin
                    w_phase_next = 1'b0;
                    if (w_last) begin
                        // line complete: replay the original request, which now hits
                        w_state_next = S_CMP;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                        w_state_next = S_FILL_M;
                    end
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_phase_next = 1'b0;
            end
        endcase
    end

    // Outputs decode from registers only, so an asynchronous reset drops them at once.
    always_comb begin
        o_cpu_rdata    = '0;
        o_cpu_ready    = 1'b0;
        o_way_en       = 1'b0;
        o_way_comp     = 1'b0;
        o_way_write    = 1'b0;
        o_way_word     = '0;
        o_way_tag      = '0;
        o_way_data_in  = '0;
        o_way_valid_in = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;

        case (r_state)
            S_CMP: begin
                o_way_en      = ~r_phase;
                o_way_comp    = 1'b1;
                o_way_write   = r_we;
                o_way_word    = r_addr.word;
                o_way_tag     = r_addr.tag;
                o_way_data_in = r_wdata;
            end
            S_WB_RD: begin
                o_way_en   = ~r_phase;
                o_way_word = r_cnt;
                o_way_tag  = r_victim_tag;
            end
            S_WB_M: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = make_addr(r_victim_tag, r_cnt);
                o_mem_wdata = r_buf;
            end
            S_FILL_M: begin
                o_mem_req  = 1'b1;
                o_mem_addr = make_addr(r_addr.tag, r_cnt);
            end
            S_FILL_W: begin
                o_way_en       = ~r_phase;
                o_way_write    = 1'b1;
                o_way_word     = r_cnt;
                o_way_tag      = r_addr.tag;
                o_way_data_in  = r_buf;
                o_way_valid_in = 1'b1;
            end
            S_RESP: begin
                o_cpu_ready = 1'b1;
                o_cpu_rdata = r_we ? '0 : r_rdata;
            end
            default: begin
                o_cpu_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural way/memory models, a flat
// shadow-memory reference, directed vectors, mid-fill reset and random traffic.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              way_en, way_comp, way_write, way_valid_in;
    logic [WORD_W-1:0] way_word;
    logic [TAG_W-1:0]  way_tag, way_tag_out;
    logic [DATA_W-1:0] way_data_in, way_data_out;
    logic              way_ack, way_hit, way_dirty, way_valid_out;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
        .o_way_en(way_en), .o_way_comp(way_comp), .o_way_write(way_write),
        .o_way_word(way_word), .o_way_tag(way_tag), .o_way_data_in(way_data_in),
        .o_way_valid_in(way_valid_in), .i_way_ack(way_ack), .i_way_hit(way_hit),
        .i_way_dirty(way_dirty), .i_way_valid_out(way_valid_out),
        .i_way_tag_out(way_tag_out), .i_way_data_out(way_data_out),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    int total = 0;
    int bad   = 0;
    int max_dly = 0;
    int way_ops = 0;
    int cmd_err = 0;
    int proto_err = 0;

    // memory and way (single line) contents
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic              line_valid, line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data [1<<WORD_W];
    logic [ADDR_W-1:0] q_wr [$];
    logic [ADDR_W-1:0] q_rd [$];

    // reference: cache is transparent, so reads return the last value written
    logic [DATA_W-1:0] shadow [1<<ADDR_W];
    logic              ref_valid, ref_dirty;
    logic [TAG_W-1:0]  ref_tag;

    logic              got, pulse_ok;
    int                lat;
    logic [DATA_W-1:0] rd_got;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        int                n_wr;
        int                n_rd;
        logic [ADDR_W-1:0] wr_base;
        logic [ADDR_W-1:0] rd_base;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin : way_model
        logic [3+WORD_W+TAG_W+DATA_W-1:0] cmd;
        int d;
        way_ack = 1'b0; way_hit = 1'b0; way_dirty = 1'b0; way_valid_out = 1'b0;
        way_tag_out = '0; way_data_out = '0;
        forever begin
            @(negedge clk);
            if (way_en && !way_ack && !rst) begin
                cmd = {way_comp, way_write, way_valid_in, way_word, way_tag, way_data_in};
                d = int'($urandom % 32'(max_dly + 1));
                repeat (d) @(negedge clk);
                if (!way_en || rst) continue;
                if (cmd !== {way_comp, way_write, way_valid_in, way_word, way_tag, way_data_in})
                    cmd_err++;
                way_ops++;
                way_hit       = line_valid && (line_tag == way_tag);
                way_dirty     = line_dirty;
                way_valid_out = line_valid;
                way_tag_out   = line_tag;
                way_data_out  = line_data[way_word];
                if (way_comp) begin
                    if (way_write && way_hit) begin
                        line_data[way_word] = way_data_in;
                        line_dirty = 1'b1;
                    end
                end else if (way_write) begin
                    line_data[way_word] = way_data_in;
                    line_tag   = way_tag;
                    line_valid = way_valid_in;
                    line_dirty = 1'b0;
                end
                way_ack = 1'b1;
                for (int k = 0; k < 200 && way_en; k++) @(negedge clk);
                d = int'($urandom % 32'(max_dly + 1));
                repeat (d) @(negedge clk);
                way_ack = 1'b0;
            end
        end
    end

    initial begin : mem_model
        int d;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                d = int'($urandom % 32'(max_dly + 1));
                repeat (d) @(negedge clk);
                if (!mem_req || rst) continue;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    q_wr.push_back(mem_addr);
                end else begin
                    mem_rdata = mem[mem_addr];
                    q_rd.push_back(mem_addr);
                end
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
    end

    // way_en must not rise while the previous command's ack is still high
    logic prev_en = 1'b0, prev_ack = 1'b0;
    always @(negedge clk) begin
        #1;
        if (way_en && !prev_en && prev_ack) proto_err++;
        prev_en  = way_en;
        prev_ack = way_ack;
    end

    task automatic ref_predict(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata,
                               output logic [DATA_W-1:0] e_rdata, output int e_nw,
                               output int e_nr, output logic [ADDR_W-1:0] e_wb,
                               output logic [ADDR_W-1:0] e_rb);
        logic [TAG_W-1:0] tag;
        tag = addr[ADDR_W-1:WORD_W];
        e_nw = 0; e_nr = 0; e_wb = '0; e_rb = '0;
        if (!(ref_valid && ref_tag == tag)) begin
            if (ref_valid && ref_dirty) begin
                e_nw = 1 << WORD_W;
                e_wb = {ref_tag, {WORD_W{1'b0}}};
            end
            e_nr = 1 << WORD_W;
            e_rb = {tag, {WORD_W{1'b0}}};
            ref_valid = 1'b1; ref_tag = tag; ref_dirty = 1'b0;
        end
        if (we) begin
            shadow[addr] = wdata;
            ref_dirty = 1'b1;
            e_rdata = '0;
        end else begin
            e_rdata = shadow[addr];
        end
    endtask

    task automatic do_txn(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
        q_wr.delete(); q_rd.delete();
        way_ops = 0; got = 1'b0; lat = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1;
                lat = n + 1;
                break;
            end
        end
        rd_got = cpu_rdata;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        pulse_ok = !cpu_ready;
    endtask

    task automatic check_txn(input string nm, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] e_rdata, input int n_wr, input int n_rd,
                             input logic [ADDR_W-1:0] wr_base, input logic [ADDR_W-1:0] rd_base);
        logic ok;
        $display("txn %s we=%0d addr=%02h rdata=%04h exp=%04h mwr=%0d mrd=%0d wayops=%0d lat=%0d",
                 nm, we, addr, rd_got, e_rdata, q_wr.size(), q_rd.size(), way_ops, lat);
        check({nm, ".done"}, got, 1);
        check({nm, ".rdata"}, rd_got, e_rdata);
        check({nm, ".pulse"}, pulse_ok, 1);
        check({nm, ".mwr_n"}, q_wr.size(), n_wr);
        check({nm, ".mrd_n"}, q_rd.size(), n_rd);
        check({nm, ".way_ops"}, way_ops, 1 + n_wr + n_rd + ((n_rd > 0) ? 1 : 0));
        if (q_wr.size() > 0) begin
            ok = 1'b1;
            foreach (q_wr[i]) if (q_wr[i] !== ADDR_W'(wr_base + ADDR_W'(i))) ok = 1'b0;
            check({nm, ".mwr_addr"}, ok, 1);
        end
        if (q_rd.size() > 0) begin
            ok = 1'b1;
            foreach (q_rd[i]) if (q_rd[i] !== ADDR_W'(rd_base + ADDR_W'(i))) ok = 1'b0;
            check({nm, ".mrd_addr"}, ok, 1);
        end
    endtask

    logic [TAG_W-1:0] rnd_tags [4];

    initial begin : main
        logic [DATA_W-1:0] e_rd;
        int                e_nw, e_nr;
        logic [ADDR_W-1:0] e_wb, e_rb;
        logic              r_we_v;
        logic [ADDR_W-1:0] r_addr_v;
        logic [DATA_W-1:0] r_wdata_v;
        logic              seen;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            mem[a]    = DATA_W'(16'h1000 + a);
            shadow[a] = DATA_W'(16'h1000 + a);
        end
        line_valid = 1'b0; line_dirty = 1'b0; line_tag = '0;
        for (int w = 0; w < (1 << WORD_W); w++) line_data[w] = '0;
        ref_valid = 1'b0; ref_dirty = 1'b0; ref_tag = '0;
        rnd_tags[0] = 5'h0A; rnd_tags[1] = 5'h0B; rnd_tags[2] = 5'h1F; rnd_tags[3] = 5'h03;

        vecs[0]  = '{1'b0, 7'h2A, 16'h0000, 16'h102A, 0, 4, 7'h00, 7'h28};
        vecs[1]  = '{1'b0, 7'h29, 16'h0000, 16'h1029, 0, 0, 7'h00, 7'h00};
        vecs[2]  = '{1'b1, 7'h2A, 16'hBEEF, 16'h0000, 0, 0, 7'h00, 7'h00};
        vecs[3]  = '{1'b0, 7'h2A, 16'h0000, 16'hBEEF, 0, 0, 7'h00, 7'h00};
        vecs[4]  = '{1'b0, 7'h2C, 16'h0000, 16'h102C, 4, 4, 7'h28, 7'h2C};
        vecs[5]  = '{1'b0, 7'h2A, 16'h0000, 16'hBEEF, 0, 4, 7'h00, 7'h28};
        vecs[6]  = '{1'b1, 7'h7F, 16'h1234, 16'h0000, 0, 4, 7'h00, 7'h7C};
        vecs[7]  = '{1'b0, 7'h7C, 16'h0000, 16'h107C, 0, 0, 7'h00, 7'h00};
        vecs[8]  = '{1'b0, 7'h00, 16'h0000, 16'h1000, 4, 4, 7'h7C, 7'h00};
        vecs[9]  = '{1'b0, 7'h7F, 16'h0000, 16'h1234, 0, 4, 7'h00, 7'h7C};
        vecs[10] = '{1'b1, 7'h03, 16'hCAFE, 16'h0000, 0, 4, 7'h00, 7'h00};
        vecs[11] = '{1'b0, 7'h03, 16'h0000, 16'hCAFE, 0, 0, 7'h00, 7'h00};

        repeat (3) @(negedge clk);
        check("reset.way_en", way_en, 0);
        check("reset.mem_req", mem_req, 0);
        check("reset.cpu_ready", cpu_ready, 0);
        check("reset.cpu_rdata", cpu_rdata, 0);
        check("reset.mem_addr", mem_addr, 0);
        check("reset.way_cmd", {way_comp, way_write, way_valid_in, way_word, way_tag}, 0);
        rst = 1'b0;

        // directed vectors with zero-latency way and memory
        for (int i = 0; i < 12; i++) begin
            ref_predict(vecs[i].we, vecs[i].addr, vecs[i].wdata, e_rd, e_nw, e_nr, e_wb, e_rb);
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].exp_rdata,
                      vecs[i].n_wr, vecs[i].n_rd, vecs[i].wr_base, vecs[i].rd_base);
            if (vecs[i].n_rd == 0) check($sformatf("vec%0d.hit_lat", i), lat, 3);
        end

        // reset while refilling: the dirty line is written back first, then FILL_M
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h40;
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (mem_req && !mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_mid.fill_seen", seen, 1);
        rst = 1'b1;
        #1;
        check("rst_mid.way_en", way_en, 0);
        check("rst_mid.mem_req", mem_req, 0);
        check("rst_mid.cpu_ready", cpu_ready, 0);
        cpu_req = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        line_valid = 1'b0; line_dirty = 1'b0;
        ref_valid = 1'b0; ref_dirty = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rel.mem_req", mem_req, 0);
        check("rst_rel.way_en", way_en, 0);
        check("rst_rel.cpu_ready", cpu_ready, 0);
        check("rst_rel.wb_data", mem[7'h03], 16'hCAFE);
        ref_predict(1'b0, 7'h41, '0, e_rd, e_nw, e_nr, e_wb, e_rb);
        do_txn(1'b0, 7'h41, '0);
        check_txn("post_rst", 1'b0, 7'h41, e_rd, e_nw, e_nr, e_wb, e_rb);

        // random traffic with slow way and memory
        max_dly = 7;
        for (int t = 0; t < 60; t++) begin
            r_we_v    = 1'($urandom_range(0, 1));
            r_addr_v  = {rnd_tags[$urandom_range(0, 3)], WORD_W'($urandom_range(0, 3))};
            r_wdata_v = DATA_W'($urandom);
            ref_predict(r_we_v, r_addr_v, r_wdata_v, e_rd, e_nw, e_nr, e_wb, e_rb);
            do_txn(r_we_v, r_addr_v, r_wdata_v);
            check_txn($sformatf("rnd%0d", t), r_we_v, r_addr_v, e_rd, e_nw, e_nr, e_wb, e_rb);
        end

        check("way_cmd_stable", cmd_err, 0);
        check("way_en_after_release", proto_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
